match_collector: RTL

MATCH_COLLECTOR -- requirements
Module: match_collector

---
 rtl/match_collector.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/match_collector.sv
// match_collector: turns sticky engine match lines into one result record per packet.
// Latency: a record is visible on res_* the cycle after its capture (registered FIFO storage).
// Backpressure: res_valid/res_ready; a record arriving at a full FIFO without a pop is dropped and counted.
// Ports: clk, rst (synchronous, active-high); sod/en/eod packet framing shared with the engines;
//   match_in sticky engine outputs; res_* record with valid/ready; drop_cnt saturating loss count;
//   busy = FSM not in IDLE.
// Config: define MATCH_COLLECTOR_POPCOUNT_EN to build the hit counter (res_hit_cnt reads 0 otherwise).

// Small generic FIFO used for the result records.
// Latency: a pushed entry is readable on pop_dat the cycle after the push.
// Backpressure: full stops pushes unless a pop happens in the same cycle.
module match_collector_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && pop_vld;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  // Head is masked while empty so the outputs read zero after reset.
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module match_collector #(
  parameter  int NUM_ENGINES  = 16,
  parameter  int FLUSH_CYCLES = 2,
  parameter  int FIFO_DEPTH   = 4,
  localparam int ID_W         = $clog2(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_pkt_seq,
  output logic [ID_W-1:0]        res_first_id,
  output logic [ID_W:0]          res_hit_cnt,
  output logic                   res_multi,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);
  localparam int REC_W = 8 + ID_W + (ID_W + 1) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, CAPTURE} state_t;

  state_t           state;
  logic [3:0]       flush_cnt;
  logic [7:0]       pkt_seq;
  logic             capture;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic [ID_W-1:0]  first_id;
  logic [ID_W:0]    hit_cnt;
  logic             multi;
  logic [REC_W-1:0] rec_dat;
  logic [REC_W-1:0] head_dat;

  // Normal capture in CAPTURE, or early capture when a new packet starts mid-flush.
  assign capture = (state == CAPTURE) || ((state == FLUSH) && sod);
  // Reset discards whatever is being captured this cycle.
  assign push    = capture && (match_in != '0) && !rst;
  assign pop     = res_valid && res_ready;
  assign busy    = (state != IDLE);

  // Lowest set bit wins: scan from the top so the last hit written is the lowest.
  always_comb begin
    first_id = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (match_in[i]) first_id = ID_W'(i);
    end
  end

`ifdef MATCH_COLLECTOR_POPCOUNT_EN
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      hit_cnt = hit_cnt + (ID_W+1)'(match_in[i]);
    end
  end
  assign multi = (hit_cnt > (ID_W+1)'(1));
`else
  assign hit_cnt = '0;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi   = ((match_in & (match_in - NUM_ENGINES'(1))) != '0);
`endif

  assign rec_dat = {pkt_seq, first_id, hit_cnt, multi};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      pkt_seq   <= '0;
      drop_cnt  <= '0;
    end else begin
      // Every capture consumes a sequence number, matched or not.
      if (capture) pkt_seq <= pkt_seq + 8'd1;
      if (push && fifo_full && !pop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (sod) begin
            state     <= (en && eod) ? FLUSH : ACTIVE;
            flush_cnt <= '0;
          end
        end
        ACTIVE: begin
          // sod without eod just restarts the packet; nothing to do here.
          if (en && eod) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (sod) begin
            state     <= (en && eod) ? FLUSH : ACTIVE;
            flush_cnt <= '0;
          end else if (en) begin
            if (flush_cnt == 4'(FLUSH_CYCLES - 1)) state <= CAPTURE;
            else flush_cnt <= flush_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          flush_cnt <= '0;
          if (sod) state <= (en && eod) ? FLUSH : ACTIVE;
          else     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  match_collector_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (rec_dat),
    .full     (fifo_full),
    .pop      (pop),
    .pop_vld  (res_valid),
    .pop_dat  (head_dat)
  );

  assign {res_pkt_seq, res_first_id, res_hit_cnt, res_multi} = head_dat;
endmodule
